// File: rtl/cl_tap_arb_pkg.sv
// Shared types and constants for the Camera Link tap arbiter.
package cl_tap_arb_pkg;

  localparam int unsigned NCH    = 3;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned LEN_W  = 9;
  localparam int unsigned STAT_W = 32;

  localparam logic [CH_W-1:0] CH_X = 2'd0;
  localparam logic [CH_W-1:0] CH_Y = 2'd1;
  localparam logic [CH_W-1:0] CH_Z = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Burst length: whatever is buffered, capped at the burst size.
  function automatic logic [LEN_W-1:0] min_len(input logic [31:0] level,
                                                input logic [31:0] burst);
    return (level < burst) ? LEN_W'(level) : LEN_W'(burst);
  endfunction

endpackage

// File: rtl/cl_rr_pick3.sv
// Three-way round-robin pick: first requester after last_grant, circular X->Y->Z.
module cl_rr_pick3
  import cl_tap_arb_pkg::*;
(
  input  logic [NCH-1:0]  req_i,
  input  logic [CH_W-1:0] last_grant_i,
  output logic [CH_W-1:0] winner_o,
  output logic            any_o
);

  logic [CH_W-1:0] c0, c1, c2;

  // Search order starting one past the previous winner.
  always_comb begin
    c0 = CH_X;
    c1 = CH_Y;
    c2 = CH_Z;
    case (last_grant_i)
      CH_X: begin c0 = CH_Y; c1 = CH_Z; c2 = CH_X; end
      CH_Y: begin c0 = CH_Z; c1 = CH_X; c2 = CH_Y; end
      default: begin c0 = CH_X; c1 = CH_Y; c2 = CH_Z; end
    endcase
  end

  // First requester in search order wins.
  always_comb begin
    winner_o = c0;
    any_o    = |req_i;
    if (req_i[c0])      winner_o = c0;
    else if (req_i[c1]) winner_o = c1;
    else if (req_i[c2]) winner_o = c2;
  end

endmodule

// File: rtl/cl_tap_arbiter.sv
// Round-robin burst arbiter sharing the PCIe DMA write path among the X/Y/Z
// Camera Link channel FIFOs. Optional statistics counters are built only
// when CL_TAP_ARB_STATS_EN is defined.
module cl_tap_arbiter
  import cl_tap_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BURST  = 16,
  parameter int unsigned LVL_W  = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NCH*LVL_W-1:0]    ch_level,
  input  logic [NCH-1:0]          ch_eof_pend,
  input  logic [NCH-1:0]          ch_valid,
  input  logic [NCH*DATA_W-1:0]   ch_data,
  input  logic [NCH-1:0]          ch_last,
  output logic [NCH-1:0]          ch_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic [LEN_W-1:0]        out_len,
  output logic                    out_sob,
  output logic                    out_eob,
  output logic                    out_last,
  output logic                    err_short,
  output logic                    busy,
  output logic [NCH*STAT_W-1:0]   stat_bursts,
  output logic [STAT_W-1:0]       stat_stall
);

  state_e           state_q, state_d;
  logic [CH_W-1:0]  sel_q, sel_d;
  logic [CH_W-1:0]  last_grant_q, last_grant_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic [NCH-1:0]   req;
  logic [LVL_W-1:0] lvl;
  logic [CH_W-1:0]  win;
  logic             any_req;
  logic [LVL_W-1:0] win_level;
  logic             sel_valid;
  logic             sel_last;
  logic [DATA_W-1:0] sel_data;
  logic             beat_done;
  logic             burst_done;

  // A channel requests with a full burst buffered or a frame tail pending.
  always_comb begin
    req = '0;
    lvl = '0;
    for (int c = 0; c < NCH; c++) begin
      lvl    = ch_level[c*LVL_W +: LVL_W];
      req[c] = (lvl != '0) && ((32'(lvl) >= BURST) || ch_eof_pend[c]);
    end
  end

  cl_rr_pick3 u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .winner_o     (win),
    .any_o        (any_req)
  );

  // Steer the granted channel's FIFO head and the winner's level.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    win_level = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel_q == CH_W'(c)) begin
        sel_valid = ch_valid[c];
        sel_last  = ch_last[c];
        sel_data  = ch_data[c*DATA_W +: DATA_W];
      end
      if (win == CH_W'(c)) win_level = ch_level[c*LVL_W +: LVL_W];
    end
  end

  // Grant/transfer FSM: next state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    ch_ready     = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_sob      = 1'b0;
    out_eob      = 1'b0;
    out_last     = 1'b0;
    err_short    = 1'b0;
    beat_done    = 1'b0;
    burst_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && any_req) begin
          sel_d        = win;
          last_grant_d = win;
          len_d        = min_len(32'(win_level), 32'(BURST));
          cnt_d        = '0;
          state_d      = XFER;
        end
      end
      XFER: begin
        out_valid = sel_valid;
        out_data  = sel_data;
        out_last  = sel_last;
        for (int c = 0; c < NCH; c++) begin
          ch_ready[c] = (sel_q == CH_W'(c)) && out_ready;
        end
        out_sob    = (cnt_q == '0);
        out_eob    = (cnt_q == len_q - LEN_W'(1)) || sel_last;
        beat_done  = out_valid && out_ready;
        burst_done = beat_done && out_eob;
        if (burst_done) begin
          state_d   = IDLE;
          err_short = sel_last && (cnt_q < len_q - LEN_W'(1));
        end else if (beat_done) begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and burst context registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sel_q        <= CH_X;
      last_grant_q <= CH_Z;
      len_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_ch  = sel_q;
  assign out_len = len_q;
  assign busy    = (state_q == XFER);

`ifdef CL_TAP_ARB_STATS_EN
  logic [STAT_W-1:0] bursts_q [NCH];
  logic [STAT_W-1:0] stall_q;

  // Completed-burst and stall counters, free-running with wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) bursts_q[c] <= '0;
      stall_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (burst_done && (sel_q == CH_W'(c))) bursts_q[c] <= bursts_q[c] + STAT_W'(1);
      end
      if (out_valid && !out_ready) stall_q <= stall_q + STAT_W'(1);
    end
  end

  // Flatten per-channel counters onto the stats bus.
  always_comb begin
    stat_bursts = '0;
    for (int c = 0; c < NCH; c++) stat_bursts[c*STAT_W +: STAT_W] = bursts_q[c];
  end
  assign stat_stall = stall_q;
`else
  assign stat_bursts = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_cl_tap_arbiter.sv
// Directed scoreboard bench for cl_tap_arbiter (stats checks follow CL_TAP_ARB_STATS_EN).
module tb_cl_tap_arbiter;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned BURST  = 16;
  localparam int unsigned LVL_W  = 10;

`ifdef CL_TAP_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [3*LVL_W-1:0]  ch_level;
  logic [2:0]        ch_eof_pend;
  logic [2:0]        ch_valid;
  logic [3*DATA_W-1:0] ch_data;
  logic [2:0]        ch_last;
  logic [2:0]        ch_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_ch;
  logic [8:0]        out_len;
  logic              out_sob, out_eob, out_last, err_short, busy;
  logic [95:0]       stat_bursts;
  logic [31:0]       stat_stall;

  cl_tap_arbiter #(.DATA_W(DATA_W), .BURST(BURST), .LVL_W(LVL_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .ch_level(ch_level), .ch_eof_pend(ch_eof_pend), .ch_valid(ch_valid),
    .ch_data(ch_data), .ch_last(ch_last), .ch_ready(ch_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_len(out_len), .out_sob(out_sob), .out_eob(out_eob),
    .out_last(out_last), .err_short(err_short), .busy(busy),
    .stat_bursts(stat_bursts), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic last; logic [63:0] data; } fw_t;
  typedef struct { logic [63:0] data; int ch; int len; bit sob; bit eob; bit last; bit err; } exp_t;

  fw_t  fq0[$], fq1[$], fq2[$];
  exp_t sb[$];

  int nvec = 0, nfail = 0, cyc = 0;
  int bonus[3], ser[3], exp_ser[3], exp_bursts[3];
  int exp_stall = 0;
  bit gap_chk = 0;
  int last_sob = -1, first_sob = -1, en_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int c, input int n);
    return (64'(c) << 56) | 64'h00BE_EF00_0000_0000 | 64'(n);
  endfunction

  function automatic int qsz(input int c);
    case (c)
      0: return fq0.size();
      1: return fq1.size();
      default: return fq2.size();
    endcase
  endfunction

  function automatic fw_t head(input int c);
    fw_t h = '0;
    case (c)
      0: if (fq0.size() != 0) h = fq0[0];
      1: if (fq1.size() != 0) h = fq1[0];
      default: if (fq2.size() != 0) h = fq2[0];
    endcase
    return h;
  endfunction

  function automatic bit haslast(input int c);
    bit r = 1'b0;
    case (c)
      0: foreach (fq0[i]) if (fq0[i].last) r = 1'b1;
      1: foreach (fq1[i]) if (fq1[i].last) r = 1'b1;
      default: foreach (fq2[i]) if (fq2[i].last) r = 1'b1;
    endcase
    return r;
  endfunction

  task automatic pop(input int c);
    case (c)
      0: if (fq0.size() != 0) void'(fq0.pop_front());
      1: if (fq1.size() != 0) void'(fq1.pop_front());
      default: if (fq2.size() != 0) void'(fq2.pop_front());
    endcase
  endtask

  task automatic load(input int c, input int n, input bit lastf);
    fw_t w;
    for (int i = 0; i < n; i++) begin
      w.data = mk(c, ser[c]);
      ser[c]++;
      w.last = lastf && (i == n-1);
      case (c)
        0: fq0.push_back(w);
        1: fq1.push_back(w);
        default: fq2.push_back(w);
      endcase
    end
  endtask

  // Expected beats: n beats of channel c in a burst whose out_len is len.
  task automatic expect_beats(input int c, input int n, input int len, input bit sobf,
                              input bit eobf, input bit lastf, input bit errf);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = mk(c, exp_ser[c]);
      exp_ser[c]++;
      e.ch   = c;
      e.len  = len;
      e.sob  = sobf && (i == 0);
      e.eob  = eobf && (i == n-1);
      e.last = lastf && (i == n-1);
      e.err  = errf && (i == n-1);
      sb.push_back(e);
    end
  endtask

  task automatic drive();
    fw_t h;
    for (int c = 0; c < 3; c++) begin
      h = head(c);
      ch_level[c*LVL_W +: LVL_W]   = LVL_W'(qsz(c) + bonus[c]);
      ch_valid[c]                  = (qsz(c) != 0);
      ch_data[c*DATA_W +: DATA_W]  = h.data;
      ch_last[c]                   = h.last;
      ch_eof_pend[c]               = haslast(c);
    end
  endtask

  // One clock: check at negedge, pop FIFOs just after posedge.
  task automatic tick();
    logic [2:0] pops;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      nvec++;
      assert (sb.size() != 0) else begin
        nfail++;
        $error("FAIL unexpected_beat observed ch=%0d data=0x%0h expected no beat", out_ch, out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data", out_data, e.data);
        chk("ch",   64'(out_ch), 64'(e.ch));
        chk("len",  64'(out_len), 64'(e.len));
        chk("sob",  64'(out_sob), 64'(e.sob));
        chk("eob",  64'(out_eob), 64'(e.eob));
        chk("last", 64'(out_last), 64'(e.last));
        chk("err_short", 64'(err_short), 64'(e.err));
        if (e.eob) exp_bursts[e.ch]++;
        if (e.sob) begin
          if (gap_chk && last_sob >= 0) chk("burst_gap", 64'(cyc - last_sob), 64'd17);
          last_sob = cyc;
          if (first_sob < 0) first_sob = cyc;
        end
      end
    end else begin
      chk("err_idle", 64'(err_short), 64'd0);
    end
    pops = ch_ready & ch_valid;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) if (pops[c]) pop(c);
    drive();
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ch_ready"},  64'(ch_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_sob"},       64'(out_sob), 64'd0);
    chk({tag, "_eob"},       64'(out_eob), 64'd0);
    chk({tag, "_last"},      64'(out_last), 64'd0);
    chk({tag, "_err"},       64'(err_short), 64'd0);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_out_ch"},    64'(out_ch), 64'd0);
    chk({tag, "_out_len"},   64'(out_len), 64'd0);
    chk({tag, "_out_data"},  out_data, 64'd0);
    for (int c = 0; c < 3; c++) chk({tag, "_stat_bursts"}, 64'(stat_bursts[c*32 +: 32]), 64'd0);
    chk({tag, "_stat_stall"}, 64'(stat_stall), 64'd0);
  endtask

  task automatic check_stats(input string tag);
    for (int c = 0; c < 3; c++)
      chk({tag, "_bursts"}, 64'(stat_bursts[c*32 +: 32]), STATS_ON ? 64'(exp_bursts[c]) : 64'd0);
    chk({tag, "_stall"}, 64'(stat_stall), STATS_ON ? 64'(exp_stall) : 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; out_ready = 1'b1;
    ch_level = '0; ch_eof_pend = '0; ch_valid = '0; ch_data = '0; ch_last = '0;
    for (int c = 0; c < 3; c++) begin
      bonus[c] = 0; ser[c] = 0; exp_ser[c] = 0; exp_bursts[c] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    // Single channel X, 16 words: one full burst, then idle.
    load(0, 16, 1'b0);
    expect_beats(0, 16, 16, 1, 1, 0, 0);
    drive();
    enable = 1'b1;
    en_cyc = cyc;
    first_sob = -1;
    drain("single_drain", 60);
    chk("req_to_first_beat", 64'(first_sob - en_cyc), 64'd2);
    chk("single_idle_busy", 64'(busy), 64'd0);

    // Short frame on Y: level 8, last on beat 3.
    load(1, 4, 1'b1);
    bonus[1] = 4;
    expect_beats(1, 4, 8, 1, 1, 1, 1);
    drive();
    drain("short_drain", 40);
    bonus[1] = 0;
    drive();
    chk("short_idle_busy", 64'(busy), 64'd0);

    // Frame tail on Z: 5 words with eof pending.
    load(2, 5, 1'b1);
    expect_beats(2, 5, 5, 1, 1, 1, 0);
    drive();
    drain("tail_drain", 40);

    // Fairness: all three request continuously for six bursts.
    for (int c = 0; c < 3; c++) load(c, 32, 1'b0);
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 3; c++) expect_beats(c, 16, 16, 1, 1, 0, 0);
    drive();
    gap_chk = 1'b1;
    last_sob = -1;
    drain("fair_drain", 200);
    gap_chk = 1'b0;
    chk("fair_idle_busy", 64'(busy), 64'd0);

    // Backpressure: out_ready pattern 1,0,0 across a 16-beat burst.
    load(0, 16, 1'b0);
    expect_beats(0, 16, 16, 1, 1, 0, 0);
    drive();
    tick();
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin
      out_ready = (k % 3 == 0);
      if (!out_ready) exp_stall++;
      tick();
    end
    out_ready = 1'b1;
    chk("bp_drain", 64'(sb.size()), 64'd0);
    chk("bp_stall_model", 64'(exp_stall), 64'd30);

    // enable drops mid-burst: burst completes, no new grant despite request.
    load(0, 32, 1'b0);
    expect_beats(0, 16, 16, 1, 1, 0, 0);
    drive();
    repeat (4) tick();
    enable = 1'b0;
    drain("en_drain", 40);
    repeat (4) begin
      tick();
      chk("en_off_busy", 64'(busy), 64'd0);
      chk("en_off_valid", 64'(out_valid), 64'd0);
    end
    check_stats("stats_mid");
    fq0.delete();
    exp_ser[0] = ser[0];
    drive();

    // Reset at beat 7 of an X burst; afterwards X wins over pending Y.
    load(0, 32, 1'b0);
    expect_beats(0, 7, 16, 1, 0, 0, 0);
    drive();
    enable = 1'b1;
    tick();
    load(1, 16, 1'b0);
    drive();
    drain("pre_reset_drain", 40);
    reset_n = 1'b0;
    #1;
    check_zero("rst_mid");
    for (int c = 0; c < 3; c++) exp_bursts[c] = 0;
    exp_stall = 0;
    tick();
    tick();
    chk("rst_hold_ready", 64'(ch_ready), 64'd0);
    reset_n = 1'b1;
    expect_beats(0, 16, 16, 1, 1, 0, 0);
    expect_beats(1, 16, 16, 1, 1, 0, 0);
    drain("post_reset_drain", 80);
    chk("final_idle_busy", 64'(busy), 64'd0);
    check_stats("stats_end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
